// File: rtl/fc3_dot_pkg.sv
// Width rules shared by the fc3 dot-product datapath.
// product_w : full-precision width of one activation x weight product
// sum_w     : width of the per-beat sum across all lanes
// acc_w     : width of the accumulated dot product over IN_DEPTH beats
// out_frac  : fractional bits of the accumulated result
package fc3_dot_pkg;

  function automatic int unsigned product_w(input int unsigned din0, input int unsigned w0);
    return din0 + w0;
  endfunction

  function automatic int unsigned sum_w(input int unsigned din0, input int unsigned w0,
                                        input int unsigned par);
    return product_w(din0, w0) + int'($clog2(par));
  endfunction

  function automatic int unsigned acc_w(input int unsigned din0, input int unsigned w0,
                                        input int unsigned par, input int unsigned depth);
    return sum_w(din0, w0, par) + int'($clog2(depth));
  endfunction

  function automatic int unsigned out_frac(input int unsigned din1, input int unsigned w1);
    return din1 + w1;
  endfunction

endpackage

// File: rtl/fc3_dot_product_lanes.sv
// Combinational lane multiply-and-sum for one beat.
// Ports:
//   data_i   : PARALLELISM signed activation lanes, lane i at [i*DIN0 +: DIN0]
//   weight_i : PARALLELISM signed weight lanes, lane i at [i*W0 +: W0]
//   sum_o    : signed full-precision sum of all lane products
module fc3_dot_product_lanes
  import fc3_dot_pkg::*;
#(
  parameter int unsigned DATA_IN_PRECISION_0 = 16,
  parameter int unsigned WEIGHT_PRECISION_0  = 16,
  parameter int unsigned PARALLELISM         = 1
) (
  input  logic        [PARALLELISM*DATA_IN_PRECISION_0-1:0]                          data_i,
  input  logic        [PARALLELISM*WEIGHT_PRECISION_0-1:0]                           weight_i,
  output logic signed [sum_w(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0, PARALLELISM)-1:0] sum_o
);

  localparam int unsigned ProdW = product_w(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0);
  localparam int unsigned SumW  = sum_w(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0, PARALLELISM);

  logic signed [ProdW-1:0] prod [PARALLELISM];

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      // Operands are sign-extended to the product width so the multiply is exact.
      prod[i] = ProdW'($signed(data_i[i*DATA_IN_PRECISION_0 +: DATA_IN_PRECISION_0])) *
                ProdW'($signed(weight_i[i*WEIGHT_PRECISION_0 +: WEIGHT_PRECISION_0]));
      sum_o   = sum_o + SumW'(prod[i]);
    end
  end

endmodule

// File: rtl/fc3_dot_accumulate.sv
// Joins the activation and weight streams beat-by-beat, sums the lane products of each beat
// (stage S1), accumulates IN_DEPTH beats and presents the dot product on a valid/ready output.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   data_in_i / _valid_i  : activation lanes and valid; data_in_ready_o accepts them
//   weight_i / _valid_i   : weight lanes and valid; weight_ready_o accepts them
//   data_out_o / _valid_o : signed dot product and valid; data_out_ready_i consumes it
module fc3_dot_accumulate
  import fc3_dot_pkg::*;
#(
  parameter int unsigned DATA_IN_PRECISION_0  = 16,
  parameter int unsigned DATA_IN_PRECISION_1  = 3,
  parameter int unsigned WEIGHT_PRECISION_0   = 16,
  parameter int unsigned WEIGHT_PRECISION_1   = 3,
  parameter int unsigned PARALLELISM          = 1,
  parameter int unsigned IN_DEPTH             = 32,
  parameter int unsigned DATA_OUT_PRECISION_0 =
      acc_w(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0, PARALLELISM, IN_DEPTH)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [PARALLELISM*DATA_IN_PRECISION_0-1:0]     data_in_i,
  input  logic                                           data_in_valid_i,
  output logic                                           data_in_ready_o,
  input  logic [PARALLELISM*WEIGHT_PRECISION_0-1:0]      weight_i,
  input  logic                                           weight_valid_i,
  output logic                                           weight_ready_o,
  output logic [DATA_OUT_PRECISION_0-1:0]                data_out_o,
  output logic                                           data_out_valid_o,
  input  logic                                           data_out_ready_i
);

  localparam int unsigned SumW    = sum_w(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0, PARALLELISM);
  localparam int unsigned AccW    = DATA_OUT_PRECISION_0;
  localparam int unsigned CntW    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(IN_DEPTH - 1);

  if (PARALLELISM < 1 || IN_DEPTH < 1) begin : g_bad_shape
    $error("PARALLELISM and IN_DEPTH must both be at least 1");
  end
  if (AccW < acc_w(DATA_IN_PRECISION_0, WEIGHT_PRECISION_0, PARALLELISM, IN_DEPTH) ||
      out_frac(DATA_IN_PRECISION_1, WEIGHT_PRECISION_1) >= AccW) begin : g_bad_width
    $error("DATA_OUT_PRECISION_0 too narrow for a full-precision dot product");
  end

  logic signed [SumW-1:0] lane_sum;
  logic signed [SumW-1:0] sum_q, sum_d;
  logic                   sum_valid_q, sum_valid_d;
  logic                   sum_first_q, sum_first_d;
  logic                   sum_last_q, sum_last_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic signed [AccW-1:0] acc_q, acc_d, acc_next;
  logic [AccW-1:0]        data_out_q, data_out_d;
  logic                   data_out_valid_q, data_out_valid_d;
  logic                   out_free, stall, advance, fire;

  fc3_dot_product_lanes #(
    .DATA_IN_PRECISION_0 (DATA_IN_PRECISION_0),
    .WEIGHT_PRECISION_0  (WEIGHT_PRECISION_0),
    .PARALLELISM         (PARALLELISM)
  ) u_lanes (
    .data_i   (data_in_i),
    .weight_i (weight_i),
    .sum_o    (lane_sum)
  );

  always_comb begin
    out_free = !data_out_valid_q || data_out_ready_i;
    // Only a finished vector can be blocked; everything upstream freezes with it.
    stall    = sum_valid_q && sum_last_q && !out_free;
    advance  = !stall;
    fire     = data_in_valid_i && weight_valid_i && advance;
    acc_next = sum_first_q ? AccW'(sum_q) : acc_q + AccW'(sum_q);

    sum_d            = sum_q;
    sum_valid_d      = sum_valid_q;
    sum_first_d      = sum_first_q;
    sum_last_d       = sum_last_q;
    cnt_d            = cnt_q;
    acc_d            = acc_q;
    data_out_d       = data_out_q;
    data_out_valid_d = data_out_valid_q;

    if (advance) begin
      sum_valid_d = fire;
      if (fire) begin
        sum_d       = lane_sum;
        sum_first_d = (cnt_q == '0);
        sum_last_d  = (cnt_q == CntLast);
      end
    end

    if (fire) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    end

    if (data_out_ready_i) begin
      data_out_valid_d = 1'b0;
    end

    if (sum_valid_q && advance) begin
      acc_d = acc_next;
      if (sum_last_q) begin
        data_out_d       = acc_next;
        data_out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q            <= '0;
      sum_valid_q      <= 1'b0;
      sum_first_q      <= 1'b0;
      sum_last_q       <= 1'b0;
      cnt_q            <= '0;
      acc_q            <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
    end else begin
      sum_q            <= sum_d;
      sum_valid_q      <= sum_valid_d;
      sum_first_q      <= sum_first_d;
      sum_last_q       <= sum_last_d;
      cnt_q            <= cnt_d;
      acc_q            <= acc_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
    end
  end

  assign data_in_ready_o  = weight_valid_i && advance;
  assign weight_ready_o   = data_in_valid_i && advance;
  assign data_out_o       = data_out_q;
  assign data_out_valid_o = data_out_valid_q;

endmodule
